// File: rtl/fft_bitrev_loader.sv
// Serial sample loader that scatters each frame into bit-reversed slots.
// Ping-pong banks; optional framing check via FFT_LOADER_LAST_CHK_EN.
module fft_bitrev_loader #(
  parameter int LOGN = 5,
  parameter int DW   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [(1<<LOGN)*DW-1:0]    frame_data,
  output logic                       err_last
);

  localparam int N = 1 << LOGN;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_st_t;

  bank_st_t          st_q [2];
  bank_st_t          st_d [2];
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [LOGN-1:0]   wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [N*DW-1:0]   bank [2];

  logic              wr;
  logic              rd;
  logic              last;
  logic [LOGN-1:0]   slot;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = v[LOGN-1-i];
    end
    return r;
  endfunction

  assign in_ready    = !reset && (st_q[wsel_q] == EMPTY);
  assign frame_valid = !reset && (st_q[rsel_q] == FULL);
  assign frame_data  = reset ? '0 : bank[rsel_q];
  assign err_last    = !reset && err_q;

  assign wr   = in_valid && in_ready;
  assign rd   = frame_valid && frame_ready;
  assign last = (wcnt_q == LOGN'(N - 1));
  assign slot = bitrev(wcnt_q);

  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    if (wr) begin
      if (last) begin
        wcnt_d       = '0;
        st_d[wsel_q] = FULL;
        wsel_d       = ~wsel_q;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    // wr and rd can only coincide on different banks
    if (rd) begin
      st_d[rsel_q] = EMPTY;
      rsel_d       = ~rsel_q;
    end
`ifdef FFT_LOADER_LAST_CHK_EN
    if (wr && (in_last != last)) begin
      err_d = 1'b1;
    end
`else
    err_d = 1'b0;
`endif
  end

`ifndef FFT_LOADER_LAST_CHK_EN
  logic unused_last;
  assign unused_last = in_last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else if (wr) begin
      for (int j = 0; j < N; j++) begin
        if (slot == LOGN'(j)) begin
          bank[wsel_q][j*DW +: DW] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed bench for fft_bitrev_loader at LOGN=5, DW=32.
// Covers load order, ping-pong backpressure, overlap, reset and gaps.
module tb_fft_bitrev_loader;

  localparam int LOGN = 5;
  localparam int DW   = 32;
  localparam int N    = 1 << LOGN;
`ifdef FFT_LOADER_LAST_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_last;
  logic              in_ready;
  logic              frame_valid;
  logic              frame_ready;
  logic [N*DW-1:0]   frame_data;
  logic              err_last;

  int checks = 0;
  int errors = 0;

  fft_bitrev_loader #(.LOGN(LOGN), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .err_last    (err_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LOGN; i++) begin
      if (v[i]) r |= 1 << (LOGN - 1 - i);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] slot(input int j);
    return frame_data[j*DW +: DW];
  endfunction

  function automatic int frame_bad(input int base);
    int bad = 0;
    for (int k = 0; k < N; k++) begin
      if (slot(rev(k)) !== DW'(base + k)) bad++;
    end
    return bad;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    frame_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    #1;
  endtask

  task automatic send(input int v, input logic lst);
    in_valid = 1'b1;
    in_data  = DW'(v);
    in_last  = lst;
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int bad;
  int nfr;
  logic [DW-1:0] s0 [3];

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    frame_ready = 1'b0;
    tick;
    tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_fvalid", frame_valid, 0);
    check("rst_fdata", {63'd0, |frame_data}, 0);
    check("rst_err", err_last, 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1);

    // basic load
    frame_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      send(k + 1, k == N - 1);
      if (k == N - 2) check("basic_pre_valid", frame_valid, 0);
    end
    check("basic_valid", frame_valid, 1);
    check("basic_slot0", slot(0), 64'h01);
    check("basic_slot1", slot(1), 64'h11);
    check("basic_slot3", slot(3), 64'h19);
    check("basic_slot31", slot(31), 64'h20);
    check("basic_frame", frame_bad(1), 0);
    check("basic_err", err_last, 0);
    tick;
    check("basic_drop", frame_valid, 0);

    // ping-pong backpressure
    do_reset;
    bad = 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!in_ready) bad++;
      send(k + 1, (k % N) == N - 1);
    end
    check("bp_ready_during", bad, 0);
    check("bp_ready_full", in_ready, 0);
    check("bp_valid_a", frame_valid, 1);
    in_valid = 1'b1;
    in_data  = 32'hdead_beef;
    tick;
    tick;
    tick;
    in_valid = 1'b0;
    check("bp_hold_a", frame_bad(1), 0);
    check("bp_still_full", in_ready, 0);
    frame_ready = 1'b1;
    tick;
    frame_ready = 1'b0;
    check("bp_valid_b", frame_valid, 1);
    check("bp_frame_b", frame_bad(N + 1), 0);
    check("bp_ready_back", in_ready, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", frame_valid, 0);
    check("rst_mid_ready", in_ready, 0);
    check("rst_mid_data", {63'd0, |frame_data}, 0);

    // overlap: three frames back to back
    do_reset;
    frame_ready = 1'b1;
    bad = 0;
    nfr = 0;
    for (int c = 0; c < 3 * N + 4; c++) begin
      if (c < 3 * N) begin
        if (!in_ready) bad++;
        in_valid = 1'b1;
        in_data  = DW'(c + 1);
        in_last  = (c % N) == N - 1;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      tick;
      if (frame_valid) begin
        if (nfr < 3) begin
          s0[nfr] = slot(0);
          if (frame_bad(nfr * N + 1) != 0) bad++;
        end
        nfr++;
      end
    end
    in_valid = 1'b0;
    check("ov_ready_and_data", bad, 0);
    check("ov_nframes", nfr, 3);
    check("ov_f0_slot0", s0[0], 64'h01);
    check("ov_f1_slot0", s0[1], 64'h21);
    check("ov_f2_slot0", s0[2], 64'h41);

    // reset mid-frame, then fresh frame
    do_reset;
    for (int k = 0; k < 10; k++) send(32'ha0 + k, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    for (int k = 0; k < N; k++) send(32'h101 + k, k == N - 1);
    check("rstmid_valid", frame_valid, 1);
    check("rstmid_frame", frame_bad(32'h101), 0);

    // gapped input
    do_reset;
    for (int k = 0; k < N; k++) begin
      send(k + 1, k == N - 1);
      if (k == N - 1) check("gap_valid", frame_valid, 1);
      tick;
    end
    check("gap_frame", frame_bad(1), 0);
    check("gap_err", err_last, 0);

    // early in_last on index 5
    do_reset;
    for (int k = 0; k < N; k++) begin
      send(k + 1, (k == 5) || (k == N - 1));
      if (k == 4) check("last_err_before", err_last, 0);
      if (k == 5) check("last_err_set", err_last, EXP_ERR);
    end
    check("last_frame_done", frame_valid, 1);
    check("last_frame", frame_bad(1), 0);
    tick;
    check("last_err_sticky", err_last, EXP_ERR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
